// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter.
// Optional build macro ALU_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FLAG = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] funsel;
    logic [7:0] a;
    logic [7:0] b;
  } alu_op_t;

  localparam logic [3:0] FS_A   = 4'b0000;
  localparam logic [3:0] FS_B   = 4'b0001;
  localparam logic [3:0] FS_NA  = 4'b0010;
  localparam logic [3:0] FS_NB  = 4'b0011;
  localparam logic [3:0] FS_ADD = 4'b0100;
  localparam logic [3:0] FS_SUB = 4'b0101;
  localparam logic [3:0] FS_AND = 4'b1000;
  localparam logic [3:0] FS_OR  = 4'b1001;
  localparam logic [3:0] FS_XOR = 4'b1010;
  localparam logic [3:0] FS_LSL = 4'b1011;
  localparam logic [3:0] FS_LSR = 4'b1100;

  localparam int ZCNO_Z = 3;
  localparam int ZCNO_C = 2;
  localparam int ZCNO_N = 1;
  localparam int ZCNO_O = 0;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Request-vector arbiter: round-robin from ptr+1, or lowest index wins when
// ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx
);

  logic found;
  int   idx;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        idx     = i;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Scan starts one past the last winner so every requester gets a turn.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found     = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_idx   = IW'(idx);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 8-bit ALU among N_REQ requesters with an accept/exec/flag/respond
// sequence. Build macro ALU_ARB_FIXED_PRIO_EN switches to fixed priority.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [4*N_REQ-1:0] req_funsel,
  input  logic [8*N_REQ-1:0] req_a,
  input  logic [8*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [7:0]         rsp_result,
  output logic [3:0]         rsp_zcno,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  output logic [3:0]         alu_funsel,
  input  logic [7:0]         alu_out,
  input  logic [3:0]         alu_zcno,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);

  state_e        state_q, state_d;
  logic [IW-1:0] g_q, g_d;
  logic [IW-1:0] last_g_q, last_g_d;
  alu_op_t       op_q, op_d;
  logic [7:0]    result_q, result_d;
  logic [3:0]    zcno_q, zcno_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_idx;
  alu_op_t          req_op;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req     (req_valid),
    .ptr     (last_g_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    req_op = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        req_op.funsel = req_funsel[4*i +: 4];
        req_op.a      = req_a[8*i +: 8];
        req_op.b      = req_b[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    last_g_d   = last_g_q;
    op_d       = op_q;
    result_d   = result_q;
    zcno_d     = zcno_q;
    req_ready  = '0;
    rsp_valid  = '0;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_funsel = 4'b0000;
    case (state_q)
      IDLE: begin
        // Gate with reset so no accept is advertised while held in reset.
        req_ready = gnt & {N_REQ{RST_N}};
        if (|req_valid) begin
          g_d     = gnt_idx;
          op_d    = req_op;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_g_d = gnt_idx;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_a      = op_q.a;
        alu_b      = op_q.b;
        alu_funsel = op_q.funsel;
        result_d   = alu_out;
        state_d    = FLAG;
      end
      FLAG: begin
        // ALU flag register captured at the end of EXEC; sample it now.
        alu_a      = op_q.a;
        alu_b      = op_q.b;
        alu_funsel = op_q.funsel;
        zcno_d     = alu_zcno;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = N_REQ'(1) << g_q;
        if (|(rsp_ready & rsp_valid)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      g_q      <= '0;
      last_g_q <= IW'(N_REQ - 1);
      op_q     <= '0;
      result_q <= 8'h00;
      zcno_q   <= 4'h0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_g_q <= last_g_d;
      op_q     <= op_d;
      result_q <= result_d;
      zcno_q   <= zcno_d;
    end
  end

  assign rsp_result = result_q;
  assign rsp_zcno   = zcno_q;
  assign busy       = (state_q != IDLE);

endmodule
